// File: rtl/clock_divide_pkg.sv
// clock_divide_pkg: shared constants, helpers and channel state for the clock divider
package clock_divide_pkg;
    localparam int DIVW_DEFAULT = 20;
    typedef enum logic {IDLE, RUN} chan_state_e;
    function automatic logic [31:0] half(input logic [31:0] n);
        return n >> 1;
    endfunction
endpackage

// File: rtl/clock_divide_chan.sv
// clock_divide_chan: one programmable divider channel with shadowed divisor and tick strobe
module clock_divide_chan
    import clock_divide_pkg::*;
#(
    parameter int DIVW        = DIVW_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            cfg_we,
    input  logic [DIVW-1:0] cfg_div,
    input  logic            sync,
    output logic            clk_div,
    output logic            tick,
    output logic [DIVW-1:0] div_cur
);
    chan_state_e     state;
    logic [DIVW-1:0] shadow, per_q, cnt, ld, last;
    logic            run, live;
    assign ld      = cfg_we ? cfg_div : shadow;
    assign last    = per_q - DIVW'(1);
    assign run     = state == RUN;
    assign live    = run && per_q != '0;
    assign clk_div = live && cnt < DIVW'(half(32'(per_q)));
    assign tick    = live && cnt == last;
    assign div_cur = per_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= DIVW'(DEFAULT_DIV);
            per_q  <= DIVW'(DEFAULT_DIV);
            cnt    <= '0;
        end else begin
            shadow <= ld;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
            end else if (!run || sync || per_q == '0 || cnt == last) begin
                state <= RUN;
                cnt   <= '0;
                per_q <= ld;
            end else
                cnt <= cnt + DIVW'(1);
        end
endmodule

// File: rtl/clock_divide_multi.sv
// clock_divide_multi: NCH runtime-programmable clock dividers with tick strobes and phase sync
module clock_divide_multi
    import clock_divide_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int DIVW        = DIVW_DEFAULT,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NCH-1:0]      en,
    input  logic [NCH-1:0]      cfg_we,
    input  logic [DIVW-1:0]     cfg_div,
    input  logic                sync,
    output logic [NCH-1:0]      clk_div,
    output logic [NCH-1:0]      tick,
    output logic [NCH*DIVW-1:0] div_cur
);
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clock_divide_chan #(
            .DIVW        (DIVW),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en[i]),
            .cfg_we  (cfg_we[i]),
            .cfg_div (cfg_div),
            .sync    (sync),
            .clk_div (clk_div[i]),
            .tick    (tick[i]),
            .div_cur (div_cur[i*DIVW +: DIVW])
        );
    end
endmodule

// File: tb/tb_clock_divide_multi.sv
// tb_clock_divide_multi: directed plus random stimulus against a period-timestamp reference model
module tb_clock_divide_multi;
    localparam int NCH  = 4;
    localparam int DIVW = 20;
    logic                clk = 0;
    logic                rst_n = 0;
    logic [NCH-1:0]      en = '0;
    logic [NCH-1:0]      cfg_we = '0;
    logic [DIVW-1:0]     cfg_div = '0;
    logic                sync = 0;
    logic [NCH-1:0]      clk_div, tick;
    logic [NCH*DIVW-1:0] div_cur;
    int                  checks = 0;
    int                  errors = 0;
    longint              cyc = 0;
    int                  m_n[NCH], m_sh[NCH];
    bit                  m_run[NCH];
    longint              m_t0[NCH];

    clock_divide_multi #(.NCH(NCH), .DIVW(DIVW), .DEFAULT_DIV(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .cfg_we  (cfg_we),
        .cfg_div (cfg_div),
        .sync    (sync),
        .clk_div (clk_div),
        .tick    (tick),
        .div_cur (div_cur)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_n[c] = 2; m_sh[c] = 2; m_run[c] = 0; m_t0[c] = 0;
        end
    endtask

    // Each period is a timestamp of its first cycle plus the divisor it runs with.
    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            int     ld;
            longint age;
            ld  = cfg_we[c] ? int'(cfg_div) : m_sh[c];
            age = cyc - m_t0[c];
            m_sh[c] = ld;
            if (!en[c]) m_run[c] = 0;
            else if (!m_run[c] || sync || m_n[c] == 0 || age == longint'(m_n[c] - 1)) begin
                m_run[c] = 1; m_n[c] = ld; m_t0[c] = cyc + 1;
            end
        end
        cyc++;
    endtask

    task automatic compare_all();
        logic [NCH-1:0]      ec, et;
        logic [NCH*DIVW-1:0] ed;
        for (int c = 0; c < NCH; c++) begin
            longint age;
            bit     live;
            age  = cyc - m_t0[c];
            live = m_run[c] && m_n[c] != 0;
            ec[c] = live && age < longint'(m_n[c] / 2);
            et[c] = live && age == longint'(m_n[c] - 1);
            ed[c*DIVW +: DIVW] = DIVW'(m_n[c]);
        end
        check("clk_div", 128'(clk_div), 128'(ec));
        check("tick", 128'(tick), 128'(et));
        check("div_cur", 128'(div_cur), 128'(ed));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic write(input logic [NCH-1:0] we, input int v);
        cfg_we = we; cfg_div = DIVW'(v);
        step();
        cfg_we = '0;
    endtask

    initial begin
        logic [4:0] pat;
        int         guard;
        model_reset();
        #12;
        check("reset_clk_div", 128'(clk_div), 0);
        check("reset_tick", 128'(tick), 0);
        check("reset_div_cur", 128'(div_cur), 128'({NCH{20'd2}}));
        @(negedge clk); rst_n = 1;
        en = 4'b0001;
        repeat (8) step();
        write(4'b0010, 5);
        en[1] = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            pat[4-k] = clk_div[1];
        end
        check("n5_pattern", 128'(pat), 128'(5'b11000));
        repeat (7) step();
        guard = 0;
        while (cyc - m_t0[1] != 2 && guard < 20) begin step(); guard++; end
        check("wait_cnt2", 128'(guard < 20), 1);
        write(4'b0010, 8);
        repeat (20) step();
        write(4'b1100, 3);
        en[2] = 1; step();
        en[3] = 1; step();
        repeat (3) step();
        sync = 1; step(); sync = 0;
        repeat (10) step();
        write(4'b0001, 1);
        repeat (3) step();
        for (int k = 0; k < 3; k++) begin
            step();
            check("n1_tick", 128'(tick[0]), 1);
            check("n1_clk", 128'(clk_div[0]), 0);
        end
        write(4'b0001, 0);
        repeat (6) step();
        check("park_out", 128'({tick[0], clk_div[0]}), 0);
        write(4'b0001, 4);
        repeat (10) step();
        #2 rst_n = 0;
        model_reset();
        #1;
        check("arst_clk_div", 128'(clk_div), 0);
        check("arst_tick", 128'(tick), 0);
        check("arst_div_cur", 128'(div_cur), 128'({NCH{20'd2}}));
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (10) step();
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 39) == 0) en[c] = ~en[c];
                cfg_we[c] = $urandom_range(0, 11) == 0;
            end
            cfg_div = ($urandom_range(0, 19) == 0) ? DIVW'($urandom) : DIVW'($urandom_range(0, 9));
            sync = $urandom_range(0, 29) == 0;
            step();
        end
        cfg_we = '0; sync = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
